// File: rtl/gcd_bist_pkg.sv
// Shared types and constants for the gcd built-in self-test controller:
// FSM state encoding, vector record layout and the fixed test-vector table.
package gcd_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int TABLE_DEPTH = 8;
  localparam int IDX_W       = 3;
  localparam int VEC_W       = 16;
  localparam int FAIL_CNT_W  = 4;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [VEC_W-1:0] expected;
  } vector_t;

  // Entry 7 is the all-zero vector and doubles as the default.
  function automatic vector_t vector_at(input logic [IDX_W-1:0] idx);
    vector_t v;
    case (idx)
      3'd0:    v = '{a: 16'd27,  b: 16'd15,  expected: 16'd3};
      3'd1:    v = '{a: 16'd21,  b: 16'd49,  expected: 16'd7};
      3'd2:    v = '{a: 16'd25,  b: 16'd30,  expected: 16'd5};
      3'd3:    v = '{a: 16'd19,  b: 16'd27,  expected: 16'd1};
      3'd4:    v = '{a: 16'd40,  b: 16'd40,  expected: 16'd40};
      3'd5:    v = '{a: 16'd250, b: 16'd190, expected: 16'd10};
      3'd6:    v = '{a: 16'd5,   b: 16'd250, expected: 16'd5};
      default: v = '{a: 16'd0,   b: 16'd0,   expected: 16'd0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gcd_bist_if.sv
// Operand/result val/rdy channel between the BIST initiator (master) and
// the gcd unit under test (slave).
interface gcd_bist_if #(
  parameter int W = 16
);
  logic [W-1:0] operands_bits_A;
  logic [W-1:0] operands_bits_B;
  logic         operands_val;
  logic         operands_rdy;
  logic [W-1:0] result_bits_data;
  logic         result_val;
  logic         result_rdy;

  modport master (
    output operands_bits_A, operands_bits_B, operands_val, result_rdy,
    input  operands_rdy, result_bits_data, result_val
  );

  modport slave (
    input  operands_bits_A, operands_bits_B, operands_val, result_rdy,
    output operands_rdy, result_bits_data, result_val
  );
endinterface

// File: rtl/gcd_bist_rom.sv
// Combinational test-vector table: index -> {A, B, expected}, with the
// 16-bit table constants zero-extended or truncated to the datapath width.
module gcd_bist_rom
  import gcd_bist_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [IDX_W-1:0] index,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     expected
);

  vector_t entry;

  always_comb entry = vector_at(index);

  assign a        = W'(entry.a);
  assign b        = W'(entry.b);
  assign expected = W'(entry.expected);

endmodule

// File: rtl/gcd_bist.sv
// BIST controller: streams the vector table into a gcd unit one transaction
// at a time, checks every result and reports pass/fail/timeout status.
module gcd_bist
  import gcd_bist_pkg::*;
#(
  parameter int W              = 16,
  parameter int NUM_VECTORS    = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  gcd_bist_if.master            bus,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0]      fail_index
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic [TO_W-1:0]  to_cnt;
  logic [W-1:0]     rom_a;
  logic [W-1:0]     rom_b;
  logic [W-1:0]     rom_exp;
  logic             start_ok;
  logic             op_fire;
  logic             res_fire;
  logic             expired;
  logic             timeout_hit;
  logic             mismatch;
  logic             last;

  gcd_bist_rom #(.W(W)) u_rom (
    .index    (index),
    .a        (rom_a),
    .b        (rom_b),
    .expected (rom_exp)
  );

  assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
  assign op_fire     = (state == ST_SEND) && bus.operands_rdy;
  assign res_fire    = (state == ST_WAIT) && bus.result_val;
  assign expired     = (state == ST_SEND || state == ST_WAIT) && (to_cnt == TO_LAST);
  // A handshake on the expiry cycle completes the transaction instead.
  assign timeout_hit = expired && !op_fire && !res_fire;
  assign mismatch    = (bus.result_bits_data != rom_exp);
  assign last        = (index == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_ok) state_next = ST_SEND;
      ST_SEND: begin
        if (op_fire)          state_next = ST_WAIT;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_WAIT: begin
        if (res_fire)         state_next = last ? ST_DONE : ST_SEND;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_DONE: if (start_ok) state_next = ST_SEND;
      default: state_next = ST_IDLE;
    endcase
  end

  // Index, timeout counter and status registers; the counter restarts on
  // every state change so each phase of a transaction gets its own budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      index      <= '0;
      to_cnt     <= '0;
      fail_count <= '0;
      fail_index <= '0;
      timeout    <= 1'b0;
    end else begin
      if (state_next != state)
        to_cnt <= '0;
      else if (state == ST_SEND || state == ST_WAIT)
        to_cnt <= to_cnt + 1'b1;

      if (start_ok) begin
        index      <= '0;
        fail_count <= '0;
        fail_index <= '0;
        timeout    <= 1'b0;
      end else if (res_fire) begin
        if (mismatch) begin
          if (fail_count != FAIL_CNT_MAX) fail_count <= fail_count + 1'b1;
          if (fail_count == '0)           fail_index <= index;
        end
        if (!last) index <= index + 1'b1;
      end else if (timeout_hit) begin
        timeout <= 1'b1;
      end
    end
  end

  assign bus.operands_val    = (state == ST_SEND);
  assign bus.operands_bits_A = (state == ST_SEND) ? rom_a : '0;
  assign bus.operands_bits_B = (state == ST_SEND) ? rom_b : '0;
  assign bus.result_rdy      = (state == ST_WAIT);

  assign done = (state == ST_DONE);
  assign pass = done && (fail_count == '0) && !timeout;

endmodule
